// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package ifetch_pkg;

    localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched (pc, instr) entries; flush wins over push.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_entry,
    output fetch_entry_t             rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues word fetches, buffers responses, feeds decode.
// Optional perf counters enabled by defining IFETCH_PERF_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFETCH_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_t  state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   rsp_pc, rsp_pc_next;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] discard_cnt, discard_cnt_next;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full, fifo_pop;
    logic          req_fire, rsp_keep, credit_ok;
    fetch_entry_t  head, wr_entry;

    // Requests in flight plus buffered entries never exceed the FIFO depth.
    assign credit_ok = (SW'(outstanding) + SW'(fifo_count)) < SW'(FIFO_DEPTH);

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        rsp_pc_next      = rsp_pc;
        discard_cnt_next = discard_cnt;
        imem_req_valid   = rst_n && (state == RUN) && credit_ok && !redirect_valid;
        req_fire         = imem_req_valid && imem_req_ready;
        rsp_keep         = imem_rsp_valid && (discard_cnt == '0);
        outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

        if (req_fire)
            fetch_pc_next = fetch_pc + 32'd4;
        if (rsp_keep)
            rsp_pc_next = rsp_pc + 32'd4;
        if (imem_rsp_valid && !rsp_keep)
            discard_cnt_next = discard_cnt - CW'(1);
        if (state == DRAIN && discard_cnt == '0)
            state_next = RUN;

        if (redirect_valid) begin
            fetch_pc_next    = redirect_pc & 32'hFFFF_FFFC;
            rsp_pc_next      = redirect_pc & 32'hFFFF_FFFC;
            discard_cnt_next = outstanding_next;
            state_next       = (outstanding_next != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            rsp_pc      <= rsp_pc_next;
            outstanding <= outstanding_next;
            discard_cnt <= discard_cnt_next;
        end
    end

    assign imem_req_addr = fetch_pc;
    assign wr_entry      = '{pc: rsp_pc, instr: imem_rsp_data};
    assign fifo_pop      = instr_valid && instr_ready;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rsp_keep),
        .pop      (fifo_pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? INSTR_NOP : head.instr;
    assign instr_pc    = fifo_empty ? 32'h0 : head.pc;

    always_ff @(posedge clk) begin
        if (rst_n && rsp_keep && !redirect_valid)
            assert (!fifo_full);
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] flush_inc;

    // A response landing in the redirect cycle is flushed along with the buffer.
    always_comb begin
        flush_inc = '0;
        if (redirect_valid)
            flush_inc = 32'(fifo_count) - 32'(fifo_pop) + 32'(rsp_keep);
        if (imem_rsp_valid && !rsp_keep)
            flush_inc = flush_inc + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(fifo_pop);
            perf_flushed <= perf_flushed + flush_inc;
        end
    end
`endif

endmodule
